// File: rtl/tc_pkg.sv
// Shared types and defaults for the serial two's-complement negation scheduler.
package tc_pkg;

    localparam int unsigned TC_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef logic [0:0] req_id_t;

endpackage

// File: rtl/tc_negate_cell.sv
// Bit-serial two's-complement negator: copy bits up to and including the first 1, invert after.
module tc_negate_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    input  logic start,
    output logic y
);

    logic seen_q;
    logic seen_eff;

    // start discards history so each word begins with no 1 seen
    always_comb begin
        seen_eff = start ? 1'b0 : seen_q;
        y        = d ^ seen_eff;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= 1'b0;
        end else begin
            seen_q <= seen_eff | d;
        end
    end

endmodule

// File: rtl/tc_serial_sched.sv
// Round-robin arbiter feeding two requesters through one shared serial negator.
// Optional res_ovf output (2^(W-1) input detect) enabled by defining TC_OVF_FLAG_EN.
module tc_serial_sched
    import tc_pkg::*;
#(
    parameter int unsigned W = TC_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_data,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_data,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_id,
    output logic         busy
`ifdef TC_OVF_FLAG_EN
    ,
    output logic         res_ovf
`endif
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    state_t         state_q;
    state_t         state_nxt;
    req_id_t        last_q;
    req_id_t        gnt_id;
    logic [W-1:0]   gnt_data;
    logic [W-1:0]   sreg_q;
    logic [CW-1:0]  cnt_q;
    logic           accept;
    logic           shift_en;
    logic           last_bit;
    logic           cell_d;
    logic           cell_start;
    logic           cell_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Arbitration, handshakes and next state; ready is only offered in IDLE
    always_comb begin
        state_nxt  = state_q;
        gnt_id     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    gnt_id = ~last_q;
                end else begin
                    gnt_id = req1_valid;
                end
                req0_ready = req0_valid && (gnt_id == 1'b0);
                req1_ready = req1_valid && (gnt_id == 1'b1);
                accept     = req0_ready || req1_ready;
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_data   = (gnt_id == 1'b1) ? req1_data : req0_data;
        shift_en   = (state_q == SHIFT);
        last_bit   = shift_en && (cnt_q == CW'(W - 1));
        cell_d     = shift_en && sreg_q[0];
        cell_start = shift_en && (cnt_q == '0);
    end

    tc_negate_cell u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cell_d),
        .start (cell_start),
        .y     (cell_y)
    );

    // Input/output shift registers, bit counter, pointer and registered status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= 1'b1;
            sreg_q    <= '0;
            cnt_q     <= '0;
            res_data  <= '0;
            res_id    <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            busy      <= (state_nxt != IDLE);
            res_valid <= (state_nxt == DONE);
            if (accept) begin
                sreg_q <= gnt_data;
                res_id <= gnt_id;
                last_q <= gnt_id;
                cnt_q  <= '0;
            end else if (shift_en) begin
                sreg_q   <= sreg_q >> 1;
                res_data <= {cell_y, res_data[W-1:1]};
                cnt_q    <= cnt_q + CW'(1);
            end
        end
    end

`ifdef TC_OVF_FLAG_EN
    // A 1 on the final bit with no earlier 1 means the input was 2^(W-1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_ovf <= 1'b0;
        end else if (last_bit) begin
            res_ovf <= cell_d & cell_y;
        end
    end
`endif

endmodule

// File: tb/tb_tc_serial_sched.sv
// Scoreboard bench for tc_serial_sched (W=8); res_ovf checked when TC_OVF_FLAG_EN is defined.
module tb_tc_serial_sched;

    logic       clk;
    logic       rst_n;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] req1_data;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_id;
    logic       busy;
`ifdef TC_OVF_FLAG_EN
    logic       res_ovf;
`endif

    typedef struct {
        logic [7:0] d;
        logic       id;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    tc_serial_sched #(.W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .busy       (busy)
`ifdef TC_OVF_FLAG_EN
        ,
        .res_ovf    (res_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Expected result from the bench's own arithmetic: -x mod 256
    task automatic exp_push(input logic [7:0] x, input logic id);
        exp_t e;
        e.d   = 8'(8'd0 - x);
        e.id  = id;
        e.ovf = (x == 8'h80);
        exp_q.push_back(e);
    endtask

    // Result consumer: compare every completed result handshake against the scoreboard
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_res", 32'(res_data), 32'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_data", 32'(res_data), 32'(e.d));
                chk("res_id", 32'(res_id), 32'(e.id));
`ifdef TC_OVF_FLAG_EN
                chk("res_ovf", 32'(res_ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // Present words on one or both ports; drop each valid after its handshake
    task automatic issue(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1);
        int budget;
        bit hs0;
        bit hs1;
        budget = 0;
        @(posedge clk); #1;
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        while ((req0_valid || req1_valid) && budget < 100) begin
            @(negedge clk);
            hs0 = req0_valid && req0_ready;
            hs1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            budget++;
            if (hs0 || hs1) acc_q.push_back(cyc);
            if (hs0) req0_valid = 1'b0;
            if (hs1) req1_valid = 1'b0;
        end
        if (req0_valid || req1_valid) begin
            chk("accept_timeout", 32'(budget), 32'(0));
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'(0));
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("rst_res_valid", 32'(res_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_res_data", 32'(res_data), 32'(0));
        chk("rst_res_id", 32'(res_id), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        acc_q.delete();
    endtask

    initial begin
        int budget;
        int a0;
        int a1;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_data = 8'h00;
        req1_valid = 1'b0; req1_data = 8'h00;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();

        // 1: latency from accept edge to res_valid
        exp_push(8'h01, 1'b0);
        issue(1'b1, 8'h01, 1'b0, 8'h00);
        a0 = acc_q.pop_front();
        budget = 0;
        @(negedge clk);
        while (!res_valid && budget < 30) begin
            @(negedge clk);
            budget++;
        end
        chk("latency", 32'(cyc - a0), 32'(8));
        drain();

        // 2: zero and the most-negative word
        exp_push(8'h00, 1'b1);
        issue(1'b0, 8'h00, 1'b1, 8'h00);
        drain();
        exp_push(8'h80, 1'b0);
        issue(1'b1, 8'h80, 1'b0, 8'h00);
        drain();

        // 3: simultaneous requests after reset, req0 wins first
        do_reset();
        exp_push(8'h05, 1'b0);
        exp_push(8'h7F, 1'b1);
        issue(1'b1, 8'h05, 1'b1, 8'h7F);
        drain();

        // 4: back-pressure in DONE
        res_ready = 1'b0;
        exp_push(8'h3A, 1'b0);
        issue(1'b1, 8'h3A, 1'b0, 8'h00);
        req0_valid = 1'b1; req0_data = 8'h11;
        req1_valid = 1'b1; req1_data = 8'h22;
        budget = 0;
        @(negedge clk);
        while (!res_valid && budget < 30) begin
            @(negedge clk);
            budget++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(res_valid), 32'(1));
            chk("hold_data", 32'(res_data), 32'hC6);
            chk("hold_id", 32'(res_id), 32'(0));
            chk("hold_busy", 32'(busy), 32'(1));
            chk("hold_rdy0", 32'(req0_ready), 32'(0));
            chk("hold_rdy1", 32'(req1_ready), 32'(0));
            @(negedge clk);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready = 1'b1;
        drain();

        // 5: reset mid-SHIFT drops the word
        issue(1'b1, 8'hAA, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(res_valid), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        acc_q.delete();
        exp_push(8'h03, 1'b0);
        issue(1'b1, 8'h03, 1'b0, 8'h00);
        drain();

        // 6: back-to-back stream at full throughput
        acc_q.delete();
        exp_push(8'h0C, 1'b0);
        exp_push(8'hF4, 1'b0);
        issue(1'b1, 8'h0C, 1'b0, 8'h00);
        issue(1'b1, 8'hF4, 1'b0, 8'h00);
        if (acc_q.size() == 2) begin
            a0 = acc_q.pop_front();
            a1 = acc_q.pop_front();
            chk("accept_spacing", 32'(a1 - a0), 32'(10));
        end else begin
            chk("accept_count", 32'(acc_q.size()), 32'(2));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
